// File: rtl/overload_frame.sv
// overload_frame
//   Generates the CAN overload frame: a dominant flag of FLAG_BITS bits, then
//   waits for the bus to go recessive (tolerating up to WAIT_LIMIT superposed
//   dominant bits from other nodes), then counts a DELIM_BITS recessive
//   delimiter and pulses endOverload back to the inter-frame-space stage.
//   At most MAX_CONSEC overload frames are sent back to back; the count is
//   cleared by SOF (isStart) or by a data/remote frame (frameReady=0).
//
// Ports
//   clock            system clock
//   reset            asynchronous, active-high
//   samplePoint      one-clock strobe at the bit sample instant
//   canRX            sampled bus level, 0 = dominant
//   frameReady       0 while a data/remote frame is in progress
//   isOverload       overload request from the inter-frame-space stage
//   isStart          SOF seen by the inter-frame-space stage
//   canTX            transmit level, 1 = recessive
//   endOverload      delimiter complete, held until the next strobe
//   overloadActive   high while in FLAG, WAIT_REC or DELIM
//   overloadRejected one-clock pulse when a request is refused
//   waitError        one-clock pulse on a bus-level error
//
// Build option
//   OVERLOAD_FORM_CHECK_EN: when defined, a dominant bit inside the delimiter
//   is treated as a form error (waitError), except on the last delimiter bit,
//   where it starts a new overload flag. When undefined, dominant delimiter
//   bits are ignored and the delimiter simply waits for more recessive bits.
//
// State table
//   state    | meaning
//   IDLE     | bus recessive, waiting for an overload request
//   FLAG     | driving the dominant overload flag
//   WAIT_REC | flag done, waiting for the bus to return recessive
//   DELIM    | counting recessive delimiter bits
//   END      | delimiter complete, endOverload held for one bit

module overload_frame #(
  parameter int FLAG_BITS  = 6,
  parameter int DELIM_BITS = 8,
  parameter int WAIT_LIMIT = 8,
  parameter int MAX_CONSEC = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic samplePoint,
  input  logic canRX,
  input  logic frameReady,
  input  logic isOverload,
  input  logic isStart,
  output logic canTX,
  output logic endOverload,
  output logic overloadActive,
  output logic overloadRejected,
  output logic waitError
);

  // bitCnt must reach the largest of the flag length, delimiter length and
  // one past the wait limit (the overrun value).
  localparam int CNT_MAX_A = (FLAG_BITS > DELIM_BITS) ? FLAG_BITS : DELIM_BITS;
  localparam int CNT_MAX   = (CNT_MAX_A > WAIT_LIMIT + 1) ? CNT_MAX_A : WAIT_LIMIT + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int CONSEC_W  = $clog2(MAX_CONSEC + 1);

  localparam logic [CNT_W-1:0]    FLAG_N     = CNT_W'(FLAG_BITS);
  localparam logic [CNT_W-1:0]    DELIM_N    = CNT_W'(DELIM_BITS);
  localparam logic [CNT_W-1:0]    WAIT_N     = CNT_W'(WAIT_LIMIT);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC);
`ifdef OVERLOAD_FORM_CHECK_EN
  localparam logic [CNT_W-1:0]    DELIM_LAST = CNT_W'(DELIM_BITS - 1);
`endif

  typedef enum logic [2:0] {IDLE, FLAG, WAIT_REC, DELIM, END} state_t;

  state_t              state;
  logic [CNT_W-1:0]    bitCnt;
  logic [CNT_W-1:0]    bitCntInc;
  logic [CONSEC_W-1:0] consec;
  logic [CONSEC_W-1:0] consecEff;

  assign bitCntInc = bitCnt + 1'b1;
  // SOF on the same strobe as a request clears the count before it is tested.
  assign consecEff = isStart ? '0 : consec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bitCnt           <= '0;
      consec           <= '0;
      canTX            <= 1'b1;
      endOverload      <= 1'b0;
      overloadActive   <= 1'b0;
      overloadRejected <= 1'b0;
      waitError        <= 1'b0;
    end else begin
      overloadRejected <= 1'b0;
      waitError        <= 1'b0;
      if (samplePoint) begin
        if (!frameReady) begin
          state          <= IDLE;
          bitCnt         <= '0;
          consec         <= '0;
          canTX          <= 1'b1;
          endOverload    <= 1'b0;
          overloadActive <= 1'b0;
        end else begin
          if (isStart) consec <= '0;
          case (state)
            IDLE: begin
              if (isOverload) begin
                if (consecEff < CONSEC_MAX) begin
                  state          <= FLAG;
                  bitCnt         <= '0;
                  canTX          <= 1'b0;
                  overloadActive <= 1'b1;
                  consec         <= consecEff + 1'b1;
                end else begin
                  overloadRejected <= 1'b1;
                end
              end
            end
            FLAG: begin
              if (bitCntInc == FLAG_N) begin
                state  <= WAIT_REC;
                bitCnt <= '0;
                canTX  <= 1'b1;
              end else begin
                bitCnt <= bitCntInc;
              end
            end
            WAIT_REC: begin
              // The first recessive bit already counts as delimiter bit 1.
              if (canRX) begin
                state  <= DELIM;
                bitCnt <= CNT_W'(1);
              end else if (bitCntInc > WAIT_N) begin
                state          <= IDLE;
                bitCnt         <= '0;
                overloadActive <= 1'b0;
                waitError      <= 1'b1;
              end else begin
                bitCnt <= bitCntInc;
              end
            end
            DELIM: begin
              if (canRX) begin
                if (bitCntInc == DELIM_N) begin
                  state          <= END;
                  bitCnt         <= '0;
                  endOverload    <= 1'b1;
                  overloadActive <= 1'b0;
                end else begin
                  bitCnt <= bitCntInc;
                end
              end
`ifdef OVERLOAD_FORM_CHECK_EN
              else if (bitCnt != DELIM_LAST) begin
                state          <= IDLE;
                bitCnt         <= '0;
                overloadActive <= 1'b0;
                waitError      <= 1'b1;
              end else if (consecEff < CONSEC_MAX) begin
                // Dominant on the last delimiter bit is another node's
                // overload request: answer it with a fresh flag.
                state  <= FLAG;
                bitCnt <= '0;
                canTX  <= 1'b0;
                consec <= consecEff + 1'b1;
              end else begin
                state            <= IDLE;
                bitCnt           <= '0;
                overloadActive   <= 1'b0;
                overloadRejected <= 1'b1;
              end
`endif
            end
            END: begin
              // A request arriving here is deliberately ignored.
              state       <= IDLE;
              endOverload <= 1'b0;
            end
            default: begin
              state          <= IDLE;
              bitCnt         <= '0;
              canTX          <= 1'b1;
              endOverload    <= 1'b0;
              overloadActive <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_overload_frame.sv
module tb_overload_frame;

  localparam int FLAG_BITS  = 6;
  localparam int DELIM_BITS = 8;
  localparam int WAIT_LIMIT = 8;
  localparam int MAX_CONSEC = 2;

  logic clock = 1'b0;
  logic reset, samplePoint, frameReady, isOverload, isStart, othersDom;
  logic canTX, endOverload, overloadActive, overloadRejected, waitError;
  wire  canRX;

  // Wired-AND bus: another node may pull it dominant.
  assign canRX = canTX & ~othersDom;

  always #5 clock = ~clock;

  overload_frame #(
    .FLAG_BITS(FLAG_BITS), .DELIM_BITS(DELIM_BITS),
    .WAIT_LIMIT(WAIT_LIMIT), .MAX_CONSEC(MAX_CONSEC)
  ) dut (
    .clock(clock), .reset(reset), .samplePoint(samplePoint), .canRX(canRX),
    .frameReady(frameReady), .isOverload(isOverload), .isStart(isStart),
    .canTX(canTX), .endOverload(endOverload), .overloadActive(overloadActive),
    .overloadRejected(overloadRejected), .waitError(waitError)
  );

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: bits of flag still to send, a "waiting for recessive"
  // phase with a dominant tally, a delimiter recessive tally, and an
  // end-hold bit. Expected outputs derive from those quantities.
  int flagLeft = 0, domAfter = 0, recCount = 0, consecutive = 0;
  bit waiting = 0, endHold = 0, mRej = 0, mWerr = 0;

  task automatic modelRequest();
    if (consecutive < MAX_CONSEC) begin
      flagLeft = FLAG_BITS;
      consecutive++;
    end else begin
      mRej = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      flagLeft = 0; domAfter = 0; recCount = 0; consecutive = 0;
      waiting = 0; endHold = 0; mRej = 0; mWerr = 0;
    end else begin
      mRej = 0; mWerr = 0;
      if (samplePoint) begin
        if (!frameReady) begin
          flagLeft = 0; waiting = 0; recCount = 0; endHold = 0; consecutive = 0;
        end else begin
          if (isStart) consecutive = 0;
          if (endHold) endHold = 0;
          else if (flagLeft > 0) begin
            flagLeft--;
            if (flagLeft == 0) begin waiting = 1; domAfter = 0; end
          end else if (waiting) begin
            if (canRX) begin waiting = 0; recCount = 1; end
            else begin
              domAfter++;
              if (domAfter > WAIT_LIMIT) begin waiting = 0; mWerr = 1; end
            end
          end else if (recCount > 0) begin
            if (canRX) begin
              recCount++;
              if (recCount == DELIM_BITS) begin recCount = 0; endHold = 1; end
            end
`ifdef OVERLOAD_FORM_CHECK_EN
            else if (recCount < DELIM_BITS - 1) begin recCount = 0; mWerr = 1; end
            else begin recCount = 0; modelRequest(); end
`endif
          end else if (isOverload) modelRequest();
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (cmpEn)
      check("cycle_outputs",
            {canTX, endOverload, overloadActive, overloadRejected, waitError},
            {(flagLeft == 0), endHold, (flagLeft > 0 || waiting || recCount > 0), mRej, mWerr});
  end

  // One bit time = 4 clocks with the strobe on the last; returns 2ns after the strobe edge.
  task automatic doBit(input logic ov, input logic st, input logic fr, input logic dom);
    isOverload = ov; isStart = st; frameReady = fr; othersDom = dom; samplePoint = 1'b0;
    repeat (3) begin @(posedge clock); #2; end
    samplePoint = 1'b1;
    @(posedge clock); #2;
    samplePoint = 1'b0;
  endtask

  logic txHist[0:40], actHist[0:40], rejHist[0:40];
  int firstEnd, endCnt, lowCnt, werrAt;

  task automatic runReq(input int nBits, input int domLo, input int domHi,
                        input int frDrop, input int reAsk);
    firstEnd = -1; endCnt = 0; lowCnt = 0; werrAt = -1;
    for (int k = 0; k <= nBits; k++) begin
      doBit(k == 0 || k == reAsk, 1'b0, !(k == frDrop), k >= domLo && k <= domHi);
      txHist[k] = canTX; actHist[k] = overloadActive; rejHist[k] = overloadRejected;
      if (endOverload === 1'b1) begin
        endCnt++;
        if (firstEnd < 0) firstEnd = k;
      end
      if (canTX === 1'b0) lowCnt++;
      if (waitError === 1'b1 && werrAt < 0) werrAt = k;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_canTX"}, canTX, 1);
    check({tag, "_endOverload"}, endOverload, 0);
    check({tag, "_overloadActive"}, overloadActive, 0);
    check({tag, "_overloadRejected"}, overloadRejected, 0);
    check({tag, "_waitError"}, waitError, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; samplePoint = 1'b0; frameReady = 1'b1;
    isOverload = 1'b0; isStart = 1'b0; othersDom = 1'b0;
    repeat (3) @(posedge clock);
    #1 checkResetOutputs("reset");
    @(posedge clock); #2;
    reset = 1'b0;
    cmpEn = 1'b1;
    doBit(1'b0, 1'b0, 1'b1, 1'b0);

    // Single request; a request during END must be ignored.
    runReq(20, -1, -1, -1, 15);
    check("single_endAt", firstEnd, 14);
    check("single_endBits", endCnt, 1);
    check("single_flagBits", lowCnt, 6);
    check("single_activeFlag", actHist[1], 1);
    check("single_endIgnore15", txHist[15], 1);
    check("single_endIgnore16", txHist[16], 1);

    // Superposed flags: three extra dominant bits after our flag.
    runReq(22, 7, 9, -1, -1);
    check("superposed_endAt", firstEnd, 17);
    check("superposed_endBits", endCnt, 1);
    check("superposed_flagBits", lowCnt, 6);

    // Third consecutive request is refused.
    runReq(3, -1, -1, -1, -1);
    check("third_rejected", rejHist[0], 1);
    check("third_noFlag", lowCnt, 0);

    // SOF clears the count; WAIT_REC stuck for nine bits.
    doBit(1'b0, 1'b1, 1'b1, 1'b0);
    runReq(20, 7, 15, -1, -1);
    check("stuck_accepted", rejHist[0], 0);
    check("stuck_waitErrorAt", werrAt, 15);
    check("stuck_noEnd", endCnt, 0);
    check("stuck_inactive", actHist[15], 0);

    // frameReady drops on flag bit 3.
    runReq(6, -1, -1, 3, -1);
    check("drop_flagBit2", txHist[2], 0);
    check("drop_canTX", txHist[3], 1);
    check("drop_inactive", actHist[3], 0);
    check("drop_flagBits", lowCnt, 3);

    // Count was cleared by the drop, so this is accepted; reset mid-DELIM.
    runReq(9, -1, -1, -1, -1);
    check("midDelim_accepted", rejHist[0], 0);
    check("midDelim_active", actHist[9], 1);
    #1 reset = 1'b1;
    #1 checkResetOutputs("asyncReset");
    @(posedge clock); #2;
    reset = 1'b0;

    // Dominant on delimiter bit 4, then on delimiter bit 8.
    runReq(20, 10, 10, -1, -1);
`ifdef OVERLOAD_FORM_CHECK_EN
    check("delim4_waitErrorAt", werrAt, 10);
    check("delim4_noEnd", endCnt, 0);
    check("delim4_inactive", actHist[10], 0);
`else
    check("delim4_endAt", firstEnd, 15);
    check("delim4_noWaitError", werrAt, -1);
`endif
    doBit(1'b0, 1'b1, 1'b1, 1'b0);
    runReq(30, 14, 14, -1, -1);
`ifdef OVERLOAD_FORM_CHECK_EN
    check("delim8_newFlag", txHist[14], 0);
    check("delim8_flagBits", lowCnt, 12);
    check("delim8_endAt", firstEnd, 28);
`else
    check("delim8_endAt", firstEnd, 15);
    check("delim8_flagBits", lowCnt, 6);
`endif
    check("delim8_endBits", endCnt, 1);

    repeat (2) doBit(1'b0, 1'b0, 1'b1, 1'b0);
    cmpEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/overload_frame.md
# overload_frame

Generates the CAN overload frame (6-bit dominant flag plus 8-bit recessive delimiter) when the inter-frame-space stage requests one. It returns `endOverload` so that stage restarts intermission at the correct bit. It sits directly downstream of the inter-frame-space stage (consumes `isOverload`, `isStart`) and feeds `endOverload` back to it, driving `canTX` toward the bit-timing/TX mux.

## Interface
- `FLAG_BITS`, 6: dominant overload-flag length in bits.
- `DELIM_BITS`, 8: recessive delimiter length in bits, including the first recessive bit seen after the flag.
- `WAIT_LIMIT`, 8: maximum extra dominant bits tolerated after our flag (superposed flags from other nodes).
- `MAX_CONSEC`, 2: maximum consecutive overload frames before further requests are rejected.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `samplePoint` in 1: one-`clock` strobe marking the bit sample instant.
- `canRX` in 1: sampled bus level (0 = dominant).
- `frameReady` in 1: 0 while a data/remote frame is in progress.
- `isOverload` in 1: overload request from the inter-frame-space stage.
- `isStart` in 1: SOF detected by the inter-frame-space stage.
- `canTX` out 1: transmit level, 1 = recessive.
- `endOverload` out 1: delimiter complete; held for one bit.
- `overloadActive` out 1: high in FLAG, WAIT_REC, DELIM.
- `overloadRejected` out 1: one-`clock` pulse when a request is refused.
- `waitError` out 1: one-`clock` pulse on WAIT_LIMIT overrun.

## Operation
- All state updates occur only on `clock` edges where `samplePoint`=1. Otherwise all registers hold, except that the pulse outputs clear.
- States:
  - **IDLE**: `canTX`=1. If `isOverload`=1 and `consec`<MAX_CONSEC, go to FLAG with `bitCnt`=0, `canTX`=0, `consec`++. If `isOverload`=1 and `consec`=MAX_CONSEC, pulse `overloadRejected` and stay in IDLE.
  - **FLAG**: `canTX`=0. Each strobe increments `bitCnt`. On the strobe where `bitCnt` reaches FLAG_BITS, set `canTX`=1, `bitCnt`=0, and go to WAIT_REC.
  - **WAIT_REC**:
    - `canRX`=1: go to DELIM with `bitCnt`=1.
    - `canRX`=0: `bitCnt`++.
    - `bitCnt` exceeds WAIT_LIMIT: pulse `waitError` and go to IDLE.
  - **DELIM**: `canTX`=1. On `canRX`=1, `bitCnt`++. When `bitCnt` reaches DELIM_BITS, go to END with `endOverload`=1. Handling of `canRX`=0 is set by the Configuration section.
  - **END**: `endOverload`=1. On the next strobe, clear `endOverload` and go to IDLE. A simultaneous `isOverload` in END is ignored; it is re-evaluated from IDLE on a later strobe.
- `consec` counter (width clog2(MAX_CONSEC+1)): cleared on reset, on a strobe with `isStart`=1, and on a strobe with `frameReady`=0.
- A strobe with `frameReady`=0 has priority over everything else: go to IDLE, `canTX`=1, `endOverload`=0, `bitCnt`=0.
- Reset mid-frame: immediate IDLE with all outputs at reset values. There is no partial-flag resume.

## Timing
- Reset values: `canTX`=1, `endOverload`=0, `overloadActive`=0, `overloadRejected`=0, `waitError`=0. State is IDLE; `consec`=0.
- All outputs are registered.
- `canTX` goes dominant in the `clock` cycle after the request strobe, so the flag starts at the next bit.
- Flag spans exactly FLAG_BITS strobes.
- `endOverload` rises one `clock` after the DELIM_BITS-th recessive sample. It falls one `clock` after the following strobe, so the upstream stage samples it high exactly once.
- Minimum request-to-`endOverload` latency: FLAG_BITS + DELIM_BITS strobes, i.e. 14 at defaults.

## Configuration
- `OVERLOAD_FORM_CHECK_EN` defined: `canRX`=0 in DELIM before the last delimiter bit pulses `waitError` and returns to IDLE without `endOverload`. `canRX`=0 on the last delimiter bit (`bitCnt`=DELIM_BITS-1) instead restarts FLAG, counting toward `consec`, or pulses `overloadRejected` if `consec`=MAX_CONSEC.
- Undefined: `canRX`=0 in DELIM is ignored; `bitCnt` holds and the block waits for the remaining recessive bits.

## Test plan
- Single request: `isOverload`=1 at one strobe, bus echoes `canTX` -> `canTX`=0 for 6 strobes, then 8 recessive strobes; `endOverload`=1 for exactly one strobe interval; `consec`=1.
- Superposed flags: `canRX`=0 for 3 extra strobes after the flag -> delimiter count starts at the first recessive bit; `endOverload` after 17 strobes total.
- Third consecutive request without `isStart` -> `overloadRejected` pulses and `canTX` stays 1. After an `isStart` strobe, a new request is accepted.
- WAIT_REC stuck: `canRX`=0 for 9 strobes after the flag -> `waitError` pulse, IDLE, `endOverload` never asserted.
- `frameReady`=0 during FLAG bit 3 -> `canTX`=1 next `clock`, `overloadActive`=0, `consec`=0. Async `reset` mid-DELIM -> all outputs at reset values without waiting for a clock edge.
- With `OVERLOAD_FORM_CHECK_EN`: dominant on delimiter bit 4 -> `waitError`; dominant on delimiter bit 8 -> new flag starts.
